// File: rtl/fetch_unit.sv
// Instruction fetch unit: run/single-step fetch FSM with a PC and relative jumps.
// A jump whose target equals its own PC stops fetching until reset.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Step,
  input  logic [7:0]  Instruction,
  output logic [7:0]  Read_Address,
  output logic [7:0]  Instr_Out,
  output logic        Instr_Valid,
  output logic        Jump_Taken,
  output logic        Trap,
  output logic [15:0] Fetch_Count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pc;
  logic       step_d;
  logic       step_rise;
  logic       fetch;
  logic       is_jump;
  logic       is_trap;
  logic [7:0] target;

  // Fetch qualification and jump decode of the byte currently addressed
  always_comb begin
    step_rise = Step & ~step_d;
    fetch     = ((state == RUN) & Run) | ((state == IDLE) & step_rise);
    is_jump   = fetch & (Instruction[7:6] == 2'b11);
    is_trap   = is_jump & (Instruction[1:0] == 2'b11);
    target    = pc + 8'd1 + {{6{Instruction[1]}}, Instruction[1:0]};
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a trap fetch wins over the run/idle decision
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (is_trap)  state_nxt = TRAP;
        else if (Run) state_nxt = RUN;
      end
      RUN: begin
        if (is_trap)   state_nxt = TRAP;
        else if (!Run) state_nxt = IDLE;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs derived directly from state and PC
  always_comb begin
    Trap         = (state == TRAP);
    Read_Address = pc;
  end

  // Fetch datapath: PC update, issued instruction, pulses and fetch counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc          <= RESET_PC;
      step_d      <= 1'b0;
      Instr_Out   <= '0;
      Instr_Valid <= 1'b0;
      Jump_Taken  <= 1'b0;
      Fetch_Count <= '0;
    end else begin
      step_d      <= Step;
      Instr_Valid <= fetch & ~is_jump;
      Jump_Taken  <= is_jump;
      if (fetch) begin
        if (Fetch_Count != '1) Fetch_Count <= Fetch_Count + 16'd1;
        if (is_jump) begin
          if (!is_trap) pc <= target;
        end else begin
          pc        <= pc + 8'd1;
          Instr_Out <= Instruction;
        end
      end
    end
  end

endmodule
